// File: rtl/riscv_ex_alu_mc_if.sv
// Handshake bundle between the EX operand muxes and the multi-cycle ALU.
// master = upstream producer/downstream consumer side, slave = the ALU.
interface riscv_ex_alu_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  // Input side: transfer when in_valid && in_ready && !flush on a rising edge.
  // Output side: out_valid holds with stable alu_out/zero_flag until out_ready.
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  zero_flag;

  modport master (
    output flush, in_valid, inst, alu_a, alu_b, out_ready,
    input  in_ready, out_valid, alu_out, zero_flag
  );

  modport slave (
    input  flush, in_valid, inst, alu_a, alu_b, out_ready,
    output in_ready, out_valid, alu_out, zero_flag
  );
endinterface

// File: rtl/riscv_ex_alu_mc.sv
// Multi-cycle EX ALU: registered base ops (latency 1) and, when RISCV_EX_MDU_EN
// is defined, an iterative shift-add multiplier / restoring divider.
module riscv_ex_alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  riscv_ex_alu_mc_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

`ifdef RISCV_EX_MDU_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd3} state_t;
`endif

  state_t       state, state_nxt, idle_target;
  logic [W-1:0] res_q;
  logic         zero_q;

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic          is_m;
  logic [3:0]    funcode;
  logic [SW-1:0] shamt;
  logic [W-1:0]  base_res;

  assign opcode = bus.inst[6:0];
  assign funct3 = bus.inst[14:12];
  assign funct7 = bus.inst[31:25];
  assign is_m   = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  assign shamt  = bus.alu_b[SW-1:0];

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.alu_out   = res_q;
  assign bus.zero_flag = zero_q;
  assign dbg_state     = state;

  always_comb begin
    funcode = 4'b0000;
    if (opcode == OPC_BRANCH)   funcode = 4'b1000;
    else if (opcode == OPC_IMM) funcode = {1'b0, funct3};
    else if (opcode == OPC_OP)  funcode = {bus.inst[30], funct3};
  end

  always_comb begin
    base_res = '0;
    case (funcode)
      4'b0000: base_res = bus.alu_a + bus.alu_b;
      4'b1000: base_res = bus.alu_a - bus.alu_b;
      4'b0001: base_res = bus.alu_a << shamt;
      4'b0010: base_res = {{(W-1){1'b0}}, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b0011: base_res = {{(W-1){1'b0}}, bus.alu_a < bus.alu_b};
      4'b0100: base_res = bus.alu_a ^ bus.alu_b;
      4'b0101: base_res = bus.alu_a >> shamt;
      4'b1101: base_res = $signed(bus.alu_a) >>> shamt;
      4'b0110: base_res = bus.alu_a | bus.alu_b;
      4'b0111: base_res = bus.alu_a & bus.alu_b;
      default: base_res = '0;
    endcase
  end

`ifdef RISCV_EX_MDU_EN
  localparam int CW = SW + 1;

  // prod holds {acc, multiplier} for MUL and {remainder, quotient} for DIV;
  // opnd holds the multiplicand or divisor magnitude.
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] prod, prod_mul, prod_div, prod_neg;
  logic [W-1:0]   opnd, a_org;
  logic [2:0]     op_q;
  logic           neg_hi, neg_rem, div_zero;
  logic           a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, rem_sh, rem_diff;
  logic [W-1:0]   quo_fin, rem_fin, mul_res, div_res, mdu_res;
  logic           mdu_last;

  assign mdu_last = (cnt == CW'(W));
  assign a_signed = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
  assign b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed & bus.alu_a[W-1];
  assign b_neg    = b_signed & bus.alu_b[W-1];
  assign a_mag    = a_neg ? -bus.alu_a : bus.alu_a;
  assign b_mag    = b_neg ? -bus.alu_b : bus.alu_b;

  always_comb begin
    mul_sum  = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? opnd : {W{1'b0}})};
    prod_mul = {mul_sum, prod[W-1:1]};
    rem_sh   = {prod[2*W-1:W], prod[W-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    // A borrow out of the trial subtraction means the quotient bit is 0.
    prod_div = rem_diff[W] ? {rem_sh[W-1:0], prod[W-2:0], 1'b0}
                           : {rem_diff[W-1:0], prod[W-2:0], 1'b1};
    prod_neg = neg_hi ? -prod : prod;
    mul_res  = (op_q == 3'b000) ? prod_neg[W-1:0] : prod_neg[2*W-1:W];
    quo_fin  = neg_hi ? -prod[W-1:0] : prod[W-1:0];
    rem_fin  = neg_rem ? -prod[2*W-1:W] : prod[2*W-1:W];
    if (div_zero) div_res = op_q[1] ? a_org : {W{1'b1}};
    else          div_res = op_q[1] ? rem_fin : quo_fin;
    mdu_res  = (state == S_MUL) ? mul_res : div_res;
  end

  always_comb begin
    idle_target = S_DONE;
    if (is_m) idle_target = funct3[2] ? S_DIV : S_MUL;
  end
`else
  always_comb begin
    idle_target = S_DONE;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) state_nxt = idle_target;
`ifdef RISCV_EX_MDU_EN
        S_MUL, S_DIV: if (mdu_last) state_nxt = S_DONE;
`endif
        S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b1;
`ifdef RISCV_EX_MDU_EN
      cnt      <= '0;
      prod     <= '0;
      opnd     <= '0;
      a_org    <= '0;
      op_q     <= '0;
      neg_hi   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else if (bus.flush) begin
`ifdef RISCV_EX_MDU_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (is_m) begin
`ifdef RISCV_EX_MDU_EN
              cnt      <= '0;
              op_q     <= funct3;
              a_org    <= bus.alu_a;
              div_zero <= (bus.alu_b == '0);
              neg_hi   <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              opnd     <= funct3[2] ? b_mag : a_mag;
              prod     <= {{W{1'b0}}, (funct3[2] ? a_mag : b_mag)};
`else
              res_q  <= '0;
              zero_q <= 1'b1;
`endif
            end else begin
              res_q  <= base_res;
              zero_q <= (base_res == '0);
            end
          end
        end
`ifdef RISCV_EX_MDU_EN
        // W iteration edges, then one edge for sign/special-case correction.
        S_MUL, S_DIV: begin
          if (mdu_last) begin
            cnt    <= '0;
            res_q  <= mdu_res;
            zero_q <= (mdu_res == '0);
          end else begin
            cnt  <= cnt + CW'(1);
            prod <= (state == S_MUL) ? prod_mul : prod_div;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_ex_alu_mc.sv
// Self-checking bench for riscv_ex_alu_mc; expectations follow RISCV_EX_MDU_EN.
`timescale 1ns/1ps
module tb_riscv_ex_alu_mc;
  localparam int W = 32;
`ifdef RISCV_EX_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  localparam int M_LAT = MDU ? W + 1 : 0;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  localparam logic [6:0] F7_M     = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [W-1:0] exp_q[$];

  riscv_ex_alu_mc_if #(.DATA_WIDTH(W), .INST_WIDTH(32)) bus ();

  riscv_ex_alu_mc #(.DATA_WIDTH(W), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  function automatic logic [31:0] base_model(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    if (f7 == F7_SUB) begin
      if (f3 == 3'b000) return a - b;
      if (f3 == 3'b101) return 32'($signed(a) >>> s);
      return 32'd0;
    end
    case (f3)
      3'd0: return a + b;
      3'd1: return a << s;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> s;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] m_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as_, au, bs, bu, p;
    int sa, sb;
    logic ovf;
    as_ = {{32{a[31]}}, a};
    au  = {32'd0, a};
    bs  = {{32{b[31]}}, b};
    bu  = {32'd0, b};
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = au * bu;  return p[31:0];  end
      3'd1: begin p = as_ * bs; return p[63:32]; end
      3'd2: begin p = as_ * bu; return p[63:32]; end
      3'd3: begin p = au * bu;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drivers: present one op for a single edge, wait for a result, consume it.
  task automatic drive_op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.inst = i; bus.alu_a = a; bus.alu_b = b; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic take_out(output logic [31:0] d, output logic z);
    d = bus.alu_out;
    z = bus.zero_flag;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.alu_out !== 32'd0) begin n_fail++; $display("FAIL reset_alu_out: got %h want 0", bus.alu_out); end
    n_checks++; if (bus.zero_flag !== 1'b1) begin n_fail++; $display("FAIL reset_zero_flag: got %b want 1", bus.zero_flag); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_base();
    logic [31:0] ti[15], ta[15], tv[15], te[15];
    logic [31:0] d, e;
    logic z;
    int edges;
    ti = '{enc(0, 3'b000, OPC_OP), enc(F7_SUB, 3'b000, OPC_OP), enc(F7_SUB, 3'b101, OPC_OP),
           enc(F7_SUB, 3'b101, OPC_OP), enc(0, 3'b101, OPC_OP), enc(0, 3'b010, OPC_OP),
           enc(0, 3'b011, OPC_OP), enc(0, 3'b100, OPC_OP), enc(0, 3'b110, OPC_OP),
           enc(0, 3'b111, OPC_OP), enc(0, 3'b001, OPC_OP), enc(F7_SUB, 3'b000, OPC_IMM),
           enc(0, 3'b001, OPC_BR), enc(0, 3'b010, OPC_LOAD), enc(F7_SUB, 3'b001, OPC_OP)};
    ta = '{32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd1, 32'd3,
           32'd10, 32'h100, 32'h1234};
    tv = '{32'd7, 32'd9, 32'd4, 32'd36, 32'd4, 32'd1, 32'd1, 32'hFF00_FF00, 32'h0F0F_0000,
           32'hFF00_FF00, 32'h3F, 32'd4, 32'd3, 32'h20, 32'd2};
    te = '{32'd12, 32'd0, 32'hF800_0000, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0,
           32'h0FF0_0FF0, 32'hFFFF_F0F0, 32'hF000_F000, 32'h8000_0000, 32'd7, 32'd7,
           32'h120, 32'd0};
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(te[k]);
      drive_op(ti[k], ta[k], tv[k]);
      wait_out(edges);
      take_out(d, z);
      e = exp_q.pop_front();
      n_checks++; if (edges !== 0) begin n_fail++; $display("FAIL base_latency[%0d]: got %0d extra edges want 0", k, edges); end
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL base_result[%0d]: got %h want %h", k, d, e); end
      n_checks++; if (z !== (e == 0)) begin n_fail++; $display("FAIL base_zero[%0d]: got %b want %b", k, z, e == 0); end
    end
  endtask

  task automatic test_mdu();
    logic [2:0]  tf[15];
    logic [31:0] ta[15], tv[15], te[15];
    logic [31:0] d, e, a, b;
    logic [2:0]  f3;
    logic z;
    int edges;
    tf = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd0, 3'd7};
    ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
           32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
           32'd5, 32'd9, 32'h12345, 32'd100};
    tv = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'h100, 32'd7};
    te = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd7,
           32'h8000_0000, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5,
           32'hFFFF_FFFF, 32'h0123_4500, 32'd2};
    for (int k = 0; k < 21; k++) begin
      if (k < 15) begin
        f3 = tf[k]; a = ta[k]; b = tv[k];
        exp_q.push_back(MDU ? te[k] : 32'd0);
      end else begin
        f3 = 3'($urandom_range(0, 7));
        a  = $urandom();
        b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        exp_q.push_back(MDU ? m_model(f3, a, b) : 32'd0);
      end
      drive_op(enc(F7_M, f3, OPC_OP), a, b);
      wait_out(edges);
      take_out(d, z);
      e = exp_q.pop_front();
      n_checks++; if (edges !== M_LAT) begin n_fail++; $display("FAIL mdu_latency[%0d]: got %0d edges want %0d", k, edges, M_LAT); end
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL mdu_result[%0d] f3=%0d a=%h b=%h: got %h want %h", k, f3, a, b, d, e); end
      n_checks++; if (z !== (e == 0)) begin n_fail++; $display("FAIL mdu_zero[%0d]: got %b want %b", k, z, e == 0); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, e, held;
    logic z;
    int edges;
    exp_q.push_back(32'h0000_2345);
    drive_op(enc(0, 3'b000, OPC_OP), 32'h1234, 32'h1111);
    wait_out(edges);
    held = bus.alu_out;
    bus.inst = enc(0, 3'b000, OPC_OP); bus.alu_a = 32'd1; bus.alu_b = 32'd1; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.alu_out !== held) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h want %h", k, bus.alu_out, held); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, bus.out_valid); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    take_out(d, z);
    e = exp_q.pop_front();
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL bp_result: got %h want %h", d, e); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_released: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic seen;
    // flush with in_valid in IDLE: nothing accepted
    @(negedge clk);
    bus.inst = enc(0, 3'b000, OPC_OP); bus.alu_a = 32'd1; bus.alu_b = 32'd2;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %b want 1", bus.in_ready); end
    // flush on MUL iteration 10, then watch long enough for a MUL to have completed
    drive_op(enc(F7_M, 3'b000, OPC_OP), 32'd3, 32'd5);
    seen = 1'b0;
    repeat (10) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    n_checks++; if (seen !== !MDU) begin n_fail++; $display("FAIL flush_pre_valid: got %b want %b", seen, !MDU); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL flush_state: got %0d want 0", dbg_state); end
    seen = 1'b0;
    repeat (40) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid: got %b want 0", seen); end
    // flush a DIV mid-way and present an ADD on the very next edge
    drive_op(enc(F7_M, 3'b100, OPC_OP), 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    exp_q.push_back(32'd30);
    bus.inst = enc(0, 3'b000, OPC_OP); bus.alu_a = 32'd10; bus.alu_b = 32'd20; bus.in_valid = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_add_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.alu_out !== exp_q[0]) begin n_fail++; $display("FAIL flush_add_result: got %h want %h", bus.alu_out, exp_q[0]); end
    void'(exp_q.pop_front());
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic z;
    int edges;
    drive_op(enc(F7_M, 3'b100, OPC_OP), 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.alu_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_alu_out: got %h want 0", bus.alu_out); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.zero_flag !== 1'b1) begin n_fail++; $display("FAIL rstmid_zero_flag: got %b want 1", bus.zero_flag); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(MDU ? ((k == 0) ? 32'd14 : 32'd2) : 32'd0);
      drive_op(enc(F7_M, (k == 0) ? 3'b100 : 3'b110, OPC_OP), 32'd100, 32'd7);
      wait_out(edges);
      take_out(d, z);
      e = exp_q.pop_front();
      n_checks++; if (edges !== M_LAT) begin n_fail++; $display("FAIL rstmid_latency[%0d]: got %0d want %0d", k, edges, M_LAT); end
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rstmid_result[%0d]: got %h want %h", k, d, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      f7 = ($urandom_range(0, 1) == 1) ? F7_SUB : 7'd0;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, bus.in_ready); end
      exp_q.push_back(base_model(f7, f3, a, b));
      bus.inst = enc(f7, f3, OPC_OP); bus.alu_a = a; bus.alu_b = b; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_checks++; if (bus.alu_out !== e) begin n_fail++; $display("FAIL b2b_result[%0d] f7=%h f3=%0d: got %h want %h", k, f7, f3, bus.alu_out, e); end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.inst = '0; bus.alu_a = '0; bus.alu_b = '0;
    test_reset();
    test_base();
    test_mdu();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_ex_alu_mc.md
# riscv_ex_alu_mc

Multi-cycle execute-stage ALU for the RISC-V core. It generalises the single-cycle integer ALU with parametrised datapath width, a valid/ready handshake on both sides, a registered result, and an iterative RV32M/RV64M multiply/divide unit. It sits in EX between the operand-forwarding muxes and the EX/MEM register, and stalls the pipeline through `in_ready`/`out_valid`.

## Interface
- `DATA_WIDTH`, 32: operand and result width, 32 or 64.
- `INST_WIDTH`, 32: instruction width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of the operation in flight.
- `in_valid`  in  1  operands and instruction valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `inst`  in  INST_WIDTH  instruction; decoding uses opcode, funct3 and funct7.
- `alu_a`, `alu_b`  in  DATA_WIDTH  operands.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `alu_out`  out  DATA_WIDTH  registered result.
- `zero_flag`  out  1  registered `alu_out == 0`.

## Operation
- Accept happens on a rising edge with `in_valid && in_ready && !flush`. `inst`, `alu_a` and `alu_b` are captured at that edge.
- Base decode produces a 4-bit funcode:
  - BRANCH: SUB.
  - OP_IMM: {0, funct3}.
  - OP with funct7 != 0000001: {inst[30], funct3}.
  - All other opcodes: ADD.
- Base operations: ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA (arithmetic), OR, AND. Any undefined funcode gives 0.
- Shift amount is the low $clog2(DATA_WIDTH) bits of `alu_b`.
- M decode: OP with funct7=0000001. funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE, on accept: base op goes to DONE with the result registered. MUL* goes to MUL. DIV*/REM* goes to DIV.
  - MUL: radix-2 shift-add over operand magnitudes. One bit per cycle for DATA_WIDTH cycles (counter 0..DATA_WIDTH-1), then to DONE. The 2·DATA_WIDTH product is sign-corrected. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - DIV: restoring division on magnitudes. One quotient bit per cycle for DATA_WIDTH cycles, then to DONE. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - DONE: `out_valid`=1. When `out_ready`=1, go to IDLE.
- MULHSU treats `alu_a` as signed and `alu_b` as unsigned.
- Divide by zero: DIV/DIVU give all-ones; REM/REMU give `alu_a`.
- Signed overflow (most-negative / -1): DIV gives the most-negative value; REM gives 0.
- Special cases still take the full iterative latency, so M latency is fixed.
- `flush` in any state: next state IDLE, `out_valid`=0, counter cleared, result discarded. If `flush` and `in_valid` are both high in IDLE, flush wins and nothing is accepted.
- `rst` forces IDLE immediately, even mid-operation. Reset values: `out_valid`=0, `alu_out`=0, `zero_flag`=1, `in_ready`=1, counter 0.

## Timing
- Base op accepted at edge E0: `out_valid` is high in the cycle after E0 (latency 1).
- M op accepted at edge E0: `out_valid` rises after edge E0+DATA_WIDTH+1. That is 33 cycles for DATA_WIDTH=32 and 65 for 64.
- Handshake completes on the edge where `out_valid && out_ready`. The next accept is possible on the following edge, so peak throughput is one base op per 2 cycles.
- While `out_valid && !out_ready`, `alu_out` and `zero_flag` are stable and `in_ready`=0.
- `in_ready` is decoded from state only; no combinational path runs from `in_valid` or `out_ready`.

## Configuration
- `RISCV_EX_MDU_EN`:
  - Defined: M decode plus the MUL and DIV states and datapath are built as described above.
  - Undefined: the MUL/DIV states and their datapath are removed. M-encoded instructions complete with latency 1 and `alu_out`=0, `zero_flag`=1. Base behaviour is unchanged.

## Test plan
- ADD, OP funct7=0 funct3=000, a=5, b=7 -> `alu_out`=12, `zero_flag`=0, `out_valid` one cycle after accept. SUB with a=b=9 -> `alu_out`=0, `zero_flag`=1.
- SRA, funct7=0100000 funct3=101, a=0x80000000, b=4 -> 0xF8000000. The same with b=36 -> 0xF8000000. SRL, a=0x80000000, b=4 -> 0x08000000.
- M ops with a=0xFFFFFFFF, b=2 -> MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHU 0x00000001, MULHSU 0xFFFFFFFF. `out_valid` exactly 33 cycles after accept.
- DIV/REM corner cases:
  - 7/0 -> DIV 0xFFFFFFFF, REM 7.
  - 0x80000000/0xFFFFFFFF -> DIV 0x80000000, REM 0.
  - -7/2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Backpressure and flush:
  - `out_ready` low for 5 cycles -> `alu_out` stable and `in_ready`=0 throughout.
  - `flush` on MUL iteration 10 -> IDLE next cycle and no `out_valid`. A new ADD is accepted on the following edge.
- Reset: `rst` asserted mid-DIV -> `out_valid`=0, `alu_out`=0 and `in_ready`=1 immediately, with no clock edge required. After release, a fresh DIV yields the correct result.
